mem_byte_bridge: RTL and testbench
==================================

Name: mem_byte_bridge

Overview:
- Sequential bus bridge between the cpu0 control unit's 32-bit memory port and a byte-wide memory array.
- Accepts one word request (read or write) and performs four consecutive big-endian byte accesses.
- Returns the assembled word with a one-cycle done pulse.
- Replaces the zero-latency word memory path, so fetch and LD/ST ticks must wait on done instead of assuming same-cycle data.

Parameters:
- ADDR_LIMIT, 128: number of valid byte addresses (0..ADDR_LIMIT-1); a word access with addr+3 >= ADDR_LIMIT faults.
- ALIGN_CHECK, 1: 1 = addr[1:0] != 0 faults; 0 = unaligned word accesses allowed.

Ports:
- clock  in  1  system clock, rising edge active
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_en  in  1  request strobe, sampled only in IDLE
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  32  byte address of the word
- req_wdata  in  32  write data, big-endian
- busy  out  1  request in progress (XFER or DONE)
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1 = request rejected, no memory access
- rdata  out  32  assembled read word; holds until the next successful read completes
- m_en  out  1  byte memory enable
- m_rw  out  1  byte memory direction, same encoding as req_rw
- m_addr  out  32  byte address
- m_wdata  out  8  write byte
- m_rdata  in  8  read byte; combinational, valid in the same cycle as m_addr/m_en

Behaviour:
- Reset (async, reset=0), all outputs forced immediately:
  - state = IDLE, byte counter k = 0
  - busy = 0, done = 0, fault = 0, rdata = 0
  - m_en = 0, m_rw = 1, m_addr = 0, m_wdata = 0
- Reset during XFER aborts at once. Bytes already written stay written; no done is issued.
- States: IDLE, XFER, DONE.
- IDLE:
  - On a rising edge with req_en = 1, latch req_rw, req_addr and req_wdata; set busy = 1.
  - If the request is out of range (req_addr + 3 >= ADDR_LIMIT, computed in 33 bits so no wrap), or misaligned with ALIGN_CHECK = 1, go to DONE with fault = 1.
  - Otherwise go to XFER with k = 0.
- XFER, cycle k (k = 0..3):
  - m_en = 1, m_rw = latched rw, m_addr = base + k.
  - m_wdata = wdata byte k, where byte 0 = bits 31:24 and byte 3 = bits 7:0.
  - On a read, m_rdata is captured at the end of the cycle into bits [31-8k -: 8] of an internal shift/assembly register.
  - After k = 3, go to DONE. rdata is updated from the assembly register only on a successful read.
- DONE:
  - done = 1 for exactly one cycle, busy = 1, fault valid, m_en = 0.
  - Next state is always IDLE.
- Latency:
  - Request sampled at edge N; m_en high in cycles N+1..N+4; done in cycle N+5.
  - Faulted request: done + fault in cycle N+1.
- req_en asserted in XFER or DONE is ignored; there is no queueing. The requester must hold or re-assert req_en after busy falls.
- A request presented on the cycle after DONE (IDLE) is accepted, giving a 6-cycle back-to-back throughput.
- m_en is low in IDLE and DONE. m_addr and m_wdata are don't-care when m_en = 0 but are driven to 0.
- fault is cleared on entry to IDLE.
- A write fault leaves memory untouched. A read fault leaves rdata unchanged.

Decomposition:
- Shared package cpu0_bus_pkg:
  - state encoding (IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2)
  - RW_READ = 1'b1, RW_WRITE = 1'b0
  - BYTES_PER_WORD = 4
- No sub-module: the counter, assembly register and FSM form one block.

Test Plan:
- Memory image {0x00,0x1F,0x00,0x18} at 0x00; read addr 0x00 -> m_addr 0,1,2,3 in cycles N+1..N+4, done at N+5, rdata = 0x001F0018, fault = 0.
- Write 0x0000002A to 0x20, then read 0x20 -> m_wdata 0x00,0x00,0x00,0x2A on m_addr 0x20..0x23; readback rdata = 0x0000002A.
- Read 0x7D (ADDR_LIMIT = 128) -> done + fault at N+1, m_en never high, rdata keeps its previous value 0x0000002A.
- Read 0x1E with ALIGN_CHECK = 1 -> fault at N+1; same read with ALIGN_CHECK = 0 -> m_addr 0x1E..0x21, no fault.
- Pulse req_en again at N+2 during XFER -> ignored, exactly one done; a new request at N+6 is accepted, second done at N+11.
- Drive reset = 0 mid-cycle while in the third XFER cycle of a write to 0x18 -> m_en and busy drop immediately without a clock edge, no done, and bytes 0x18 and 0x19 are already written.

Source files
------------

// File: rtl/cpu0_bus_pkg.sv
// Shared definitions for the cpu0 memory bus: bridge state encoding, access direction, word geometry.
// Latency: n/a (types, constants and a byte-select helper only).
// Backpressure: n/a.
package cpu0_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic RW_READ        = 1'b1;
  localparam logic RW_WRITE       = 1'b0;
  localparam int   BYTES_PER_WORD = 4;

  // Big-endian byte select: byte 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_byte_bridge.sv
// Bridges a 32-bit word request onto a byte-wide memory as four big-endian byte accesses.
// Latency: request sampled at edge N, bytes on cycles N+1..N+4, done at N+5; faulted request done at N+1.
// Backpressure: none queued; req_en is only sampled in IDLE, so the requester holds or re-asserts it after busy falls.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   req_en/rw/addr/wdata    word request (rw: 1 = read, 0 = write)
//   busy, done, fault       status; done is a one-cycle pulse, fault is valid with done
//   rdata                   last successfully read word
//   m_en/rw/addr/wdata      byte memory command
//   m_rdata                 byte memory read data, combinational from m_addr
module mem_byte_bridge
  import cpu0_bus_pkg::*;
#(
  parameter int ADDR_LIMIT  = 128,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_en,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        m_en,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata
);

  state_t      state;
  logic [1:0]  k;
  logic        rw_q;
  logic [31:0] wdata_q;
  // Holds the first three bytes of a read; the fourth byte joins them directly into rdata.
  logic [23:0] asm_q;
  logic        req_bad;

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    req_bad = (({1'b0, req_addr} + 33'd3) >= 33'(ADDR_LIMIT));
    if ((ALIGN_CHECK != 0) && (req_addr[1:0] != 2'b00)) begin
      req_bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      k       <= 2'd0;
      rw_q    <= RW_READ;
      wdata_q <= 32'd0;
      asm_q   <= 24'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      rdata   <= 32'd0;
      m_en    <= 1'b0;
      m_rw    <= RW_READ;
      m_addr  <= 32'd0;
      m_wdata <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
          if (req_en) begin
            rw_q    <= req_rw;
            wdata_q <= req_wdata;
            busy    <= 1'b1;
            if (req_bad) begin
              // Rejected requests never touch memory: straight to DONE with fault.
              state <= ST_DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state   <= ST_XFER;
              k       <= 2'd0;
              m_en    <= 1'b1;
              m_rw    <= req_rw;
              m_addr  <= req_addr;
              m_wdata <= word_byte(req_wdata, 2'd0);
            end
          end
        end

        ST_XFER: begin
          if (rw_q == RW_READ) begin
            asm_q <= {asm_q[15:0], m_rdata};
          end
          if (k == 2'(BYTES_PER_WORD - 1)) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            m_en    <= 1'b0;
            m_rw    <= RW_READ;
            m_addr  <= 32'd0;
            m_wdata <= 8'd0;
            if (rw_q == RW_READ) begin
              rdata <= {asm_q, m_rdata};
            end
          end else begin
            k       <= k + 2'd1;
            m_addr  <= m_addr + 32'd1;
            m_wdata <= word_byte(wdata_q, k + 2'd1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          fault <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          fault <= 1'b0;
          m_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Self-checking bench for mem_byte_bridge: one instance with alignment checking, one without.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_byte_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_en_a = 1'b0, req_en_b = 1'b0;
  logic        req_rw = 1'b1;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

  logic        busy_a, done_a, fault_a, m_en_a, m_rw_a;
  logic [31:0] rdata_a, m_addr_a;
  logic [7:0]  m_wdata_a, m_rdata_a;
  logic        busy_b, done_b, fault_b, m_en_b, m_rw_b;
  logic [31:0] rdata_b, m_addr_b;
  logic [7:0]  m_wdata_b, m_rdata_b;

  logic [7:0]  mem_a [128];
  logic [7:0]  mem_b [128];
  logic        load_en = 1'b0;
  logic [6:0]  load_addr = 7'd0;
  logic [7:0]  load_dat = 8'd0;

  // Reference model state.
  logic [7:0]  ref_a [128];
  logic [7:0]  ref_b [128];
  logic [31:0] mdl_rdata [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_byte_bridge #(.ADDR_LIMIT(128), .ALIGN_CHECK(1)) dut_a (
    .clock(clock), .reset(reset), .req_en(req_en_a), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy_a), .done(done_a),
    .fault(fault_a), .rdata(rdata_a), .m_en(m_en_a), .m_rw(m_rw_a),
    .m_addr(m_addr_a), .m_wdata(m_wdata_a), .m_rdata(m_rdata_a));

  mem_byte_bridge #(.ADDR_LIMIT(128), .ALIGN_CHECK(0)) dut_b (
    .clock(clock), .reset(reset), .req_en(req_en_b), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy_b), .done(done_b),
    .fault(fault_b), .rdata(rdata_b), .m_en(m_en_b), .m_rw(m_rw_b),
    .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b));

  always @(posedge clock) begin
    if (load_en) begin
      mem_a[load_addr] <= load_dat;
      mem_b[load_addr] <= load_dat;
    end else begin
      if (m_en_a && !m_rw_a) mem_a[m_addr_a[6:0]] <= m_wdata_a;
      if (m_en_b && !m_rw_b) mem_b[m_addr_b[6:0]] <= m_wdata_b;
    end
  end
  assign m_rdata_a = mem_a[m_addr_a[6:0]];
  assign m_rdata_b = mem_b[m_addr_b[6:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit model_fault(input bit sel, input logic [31:0] addr);
    longint unsigned last = longint'(addr) + 3;
    return (last >= 128) || (!sel && (addr % 4 != 0));
  endfunction

  function automatic logic [31:0] model_word(input bit sel, input logic [31:0] addr);
    logic [31:0] w = 0;
    for (int i = 0; i < 4; i++) w = (w << 8) | (sel ? ref_b[addr + i] : ref_a[addr + i]);
    return w;
  endfunction

  // Issues one request and checks every cycle until one cycle after done.
  task automatic run_req(input bit sel, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit exp_fault,
                         input logic [31:0] exp_rdata, input string tag);
    int lat = exp_fault ? 1 : 5;
    logic s_busy, s_done, s_fault, s_en, s_rw;
    logic [31:0] s_addr, s_rdata;
    logic [7:0] s_wdata;
    @(negedge clock);
    req_rw = rw; req_addr = addr; req_wdata = wdata;
    if (sel) req_en_b = 1'b1; else req_en_a = 1'b1;
    @(posedge clock);
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clock);
      if (j == 1) begin req_en_a = 1'b0; req_en_b = 1'b0; end
      s_busy  = sel ? busy_b    : busy_a;
      s_done  = sel ? done_b    : done_a;
      s_fault = sel ? fault_b   : fault_a;
      s_en    = sel ? m_en_b    : m_en_a;
      s_rw    = sel ? m_rw_b    : m_rw_a;
      s_addr  = sel ? m_addr_b  : m_addr_a;
      s_wdata = sel ? m_wdata_b : m_wdata_a;
      s_rdata = sel ? rdata_b   : rdata_a;
      chk({tag, "_done"}, s_done, (j == lat));
      chk({tag, "_busy"}, s_busy, (j <= lat));
      chk({tag, "_men"},  s_en,   (!exp_fault && j <= 4));
      if (!exp_fault && j <= 4) begin
        chk({tag, "_maddr"}, s_addr, addr + j - 1);
        chk({tag, "_mrw"},   s_rw, rw);
        if (!rw) chk({tag, "_mwdata"}, s_wdata, (wdata >> (8 * (4 - j))) & 32'hFF);
      end else begin
        chk({tag, "_idle_bus"}, {s_addr, s_wdata}, 0);
      end
      if (j == lat)     chk({tag, "_fault"}, s_fault, exp_fault);
      if (j == lat + 1) begin
        chk({tag, "_rdata"}, s_rdata, exp_rdata);
        chk({tag, "_fault_clr"}, s_fault, 0);
      end
    end
    if (!exp_fault && !rw) begin
      for (int i = 0; i < 4; i++) begin
        if (sel) ref_b[addr + i] = 8'(wdata >> (24 - 8 * i));
        else     ref_a[addr + i] = 8'(wdata >> (24 - 8 * i));
      end
    end
    mdl_rdata[sel] = exp_rdata;
  endtask

  typedef struct {
    bit          sel;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : main
    logic [7:0] img [4];
    int mism;
    bit sel, rw, f;
    logic [31:0] addr, wdata, er;

    vecs[0]  = '{0, 1, 32'h00,       32'h0,        0, 32'h001F0018};
    vecs[1]  = '{0, 0, 32'h20,       32'h0000002A, 0, 32'h001F0018};
    vecs[2]  = '{0, 1, 32'h20,       32'h0,        0, 32'h0000002A};
    vecs[3]  = '{0, 1, 32'h7D,       32'h0,        1, 32'h0000002A};
    vecs[4]  = '{0, 1, 32'h1E,       32'h0,        1, 32'h0000002A};
    vecs[5]  = '{0, 0, 32'h7C,       32'hCAFEF00D, 0, 32'h0000002A};
    vecs[6]  = '{0, 1, 32'h7C,       32'h0,        0, 32'hCAFEF00D};
    vecs[7]  = '{0, 0, 32'h7E,       32'hFFFFFFFF, 1, 32'hCAFEF00D};
    vecs[8]  = '{0, 1, 32'hFFFFFFFC, 32'h0,        1, 32'hCAFEF00D};
    vecs[9]  = '{1, 0, 32'h1E,       32'h11223344, 0, 32'h00000000};
    vecs[10] = '{1, 1, 32'h1E,       32'h0,        0, 32'h11223344};
    vecs[11] = '{1, 1, 32'h7D,       32'h0,        1, 32'h11223344};
    vecs[12] = '{1, 0, 32'h7A,       32'h55667788, 0, 32'h11223344};
    vecs[13] = '{1, 1, 32'h7A,       32'h0,        0, 32'h55667788};

    img[0] = 8'h00; img[1] = 8'h1F; img[2] = 8'h00; img[3] = 8'h18;
    mdl_rdata[0] = 0; mdl_rdata[1] = 0;

    // Preload both memories under reset.
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      load_en = 1'b1; load_addr = 7'(i);
      load_dat = (i < 4) ? img[i] : 8'($urandom);
      ref_a[i] = load_dat; ref_b[i] = load_dat;
    end
    @(negedge clock);
    load_en = 1'b0;

    chk("rst_a_ctl",   {busy_a, done_a, fault_a, m_en_a, m_rw_a}, 5'b00001);
    chk("rst_a_rdata", rdata_a, 0);
    chk("rst_a_bus",   {m_addr_a, m_wdata_a}, 0);
    chk("rst_b_ctl",   {busy_b, done_b, fault_b, m_en_b, m_rw_b}, 5'b00001);
    chk("rst_b_rdata", rdata_b, 0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++)
      run_req(vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_fault, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Strobe during XFER is ignored; a request right after DONE is accepted.
    @(negedge clock);
    req_rw = 1'b1; req_addr = 32'h00; req_en_a = 1'b1;
    @(posedge clock);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clock);
      chk($sformatf("b2b_done_%0d", j), done_a, (j == 5 || j == 11));
      chk($sformatf("b2b_men_%0d", j), m_en_a, ((j >= 1 && j <= 4) || (j >= 7 && j <= 10)));
      if (j >= 1 && j <= 4)  chk($sformatf("b2b_addr_%0d", j), m_addr_a, j - 1);
      if (j >= 7 && j <= 10) chk($sformatf("b2b_addr_%0d", j), m_addr_a, 32'h20 + j - 7);
      if (j == 6)  chk("b2b_rdata1", rdata_a, model_word(0, 32'h00));
      if (j == 12) chk("b2b_rdata2", rdata_a, model_word(0, 32'h20));
      req_en_a = (j == 2 || j == 6);
      if (j == 2) begin req_rw = 1'b0; req_addr = 32'h40; req_wdata = 32'hDEADBEEF; end
      if (j == 6) begin req_rw = 1'b1; req_addr = 32'h20; end
    end
    req_en_a = 1'b0;
    mdl_rdata[0] = model_word(0, 32'h20);

    // Asynchronous reset in the third XFER cycle of a write.
    @(negedge clock);
    req_rw = 1'b0; req_addr = 32'h18; req_wdata = 32'hA1B2C3D4; req_en_a = 1'b1;
    @(posedge clock);
    @(negedge clock); req_en_a = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rstx_pre_addr", {m_en_a, m_addr_a}, {1'b1, 32'h1A});
    reset = 1'b0;
    #1;
    chk("rstx_men", m_en_a, 0);
    chk("rstx_busy", busy_a, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      chk("rstx_nodone", done_a, 0);
    end
    reset = 1'b1;
    chk("rstx_b18", mem_a[8'h18], 8'hA1);
    chk("rstx_b19", mem_a[8'h19], 8'hB2);
    chk("rstx_b1a", mem_a[8'h1A], ref_a[8'h1A]);
    chk("rstx_b1b", mem_a[8'h1B], ref_a[8'h1B]);
    chk("rstx_rdata", rdata_a, 0);
    ref_a[8'h18] = 8'hA1; ref_a[8'h19] = 8'hB2;
    mdl_rdata[0] = 0; mdl_rdata[1] = 0;

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 131));
      if (!sel && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      wdata = $urandom;
      f  = model_fault(sel, addr);
      er = (!f && rw) ? model_word(sel, addr) : mdl_rdata[sel];
      run_req(sel, rw, addr, wdata, f, er, $sformatf("rnd%0d", n));
    end

    mism = 0;
    for (int i = 0; i < 128; i++) begin
      if (mem_a[i] !== ref_a[i]) mism++;
      if (mem_b[i] !== ref_b[i]) mism++;
    end
    chk("mem_final", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
